// File: rtl/mpadd_pkg.sv
// Shared types and constants for the multi-precision adder sequencer.
package mpadd_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

endpackage

// File: rtl/mpadd_add8_cla.sv
// Combinational 8-bit carry-lookahead adder; c7 is the carry into the top bit.
module add8_cla
   import mpadd_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              ci,
   output logic [BYTE_W-1:0] s,
   output logic              co,
   output logic              c7
);

   logic [BYTE_W-1:0] g, p;
   logic [BYTE_W:0]   c;
   logic              acc, pr;

   // Each carry is the flattened sum-of-products of generate/propagate terms.
   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c    = '0;
      c[0] = ci;
      acc  = 1'b0;
      pr   = 1'b0;
      for (int i = 0; i < BYTE_W; i++) begin
         acc = g[i];
         pr  = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            acc = acc | (pr & g[j]);
            pr  = pr & p[j];
         end
         c[i+1] = acc | (pr & ci);
      end
   end

   assign s  = p ^ c[BYTE_W-1:0];
   assign co = c[BYTE_W];
   assign c7 = c[BYTE_W-1];

endmodule

// File: rtl/mpadd_seq.sv
// Byte-serial multi-precision adder with valid/ready on both sides.
// Define MPADD_SUB_EN to make the sub input select A - B.
module mpadd_seq
   import mpadd_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BYTE_W*WORDS-1:0] a,
   input  logic [BYTE_W*WORDS-1:0] b,
   input  logic                  cin,
   input  logic                  sub,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BYTE_W*WORDS-1:0] sum,
   output logic                  cout,
   output logic                  ovf
);

   localparam int W     = BYTE_W * WORDS;
   localparam int IDX_W = (clog2(WORDS) > 0) ? clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST      = IDX_W'(WORDS - 1);
   localparam logic [W-1:0]     BYTE_MASK = W'({BYTE_W{1'b1}});

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              carry_q, carry_d;
   logic              sub_q, sub_d;
   logic [W-1:0]      a_q, a_d, b_q, b_d;
   logic [W-1:0]      sum_q, sum_d;
   logic              cout_q, cout_d, ovf_q, ovf_d;

   logic [BYTE_W-1:0] a_byte, b_byte, b_raw, s8;
   logic              c8, c7;
   logic              sub_eff;
   int                sh;

`ifdef MPADD_SUB_EN
   assign sub_eff = sub;
`else
   logic sub_unused;
   assign sub_unused = sub;
   assign sub_eff    = 1'b0;
`endif

   assign sh     = BYTE_W * int'(idx_q);
   assign a_byte = BYTE_W'(a_q >> sh);
   assign b_raw  = BYTE_W'(b_q >> sh);
   assign b_byte = sub_q ? ~b_raw : b_raw;

   add8_cla u_add (
      .a  (a_byte),
      .b  (b_byte),
      .ci (carry_q),
      .s  (s8),
      .co (c8),
      .c7 (c7)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      carry_d   = carry_q;
      sub_d     = sub_q;
      a_d       = a_q;
      b_d       = b_q;
      sum_d     = sum_q;
      cout_d    = cout_q;
      ovf_d     = ovf_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               sub_d   = sub_eff;
               carry_d = sub_eff ? 1'b1 : cin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d   = (sum_q & ~(BYTE_MASK << sh)) | (W'(s8) << sh);
            carry_d = c8;
            if (idx_q == LAST) begin
               cout_d  = c8;
               ovf_d   = c7 ^ c8;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         sub_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         sub_q   <= sub_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule
